// File: rtl/count_sched_pkg.sv
// Shared types and default widths for the mode-counter run scheduler.
package count_sched_pkg;

  localparam int unsigned StepWDefault = 4;
  localparam int unsigned ModeWDefault = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/count_mode_sched_if.sv
// Requester/counter-side signal bundle for count_mode_sched.
interface count_mode_sched_if #(
  parameter int unsigned STEP_W = count_sched_pkg::StepWDefault,
  parameter int unsigned MODE_W = count_sched_pkg::ModeWDefault
);

  logic              req0;
  logic              req1;
  logic [MODE_W-1:0] mode0;
  logic [MODE_W-1:0] mode1;
  logic [STEP_W-1:0] steps0;
  logic [STEP_W-1:0] steps1;
  logic              abort;
  logic              gnt0;
  logic              gnt1;
  logic [MODE_W-1:0] mode;
  logic              step_en;
  logic              owner;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output req0, req1, mode0, mode1, steps0, steps1, abort,
    input  gnt0, gnt1, mode, step_en, owner, busy, done, aborted
  );

  modport slave (
    input  req0, req1, mode0, mode1, steps0, steps1, abort,
    output gnt0, gnt1, mode, step_en, owner, busy, done, aborted
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-winner state lives in the parent.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win,
  output logic valid
);

  assign valid = req0 | req1;
  // On contention the requester that did not win last time goes first.
  assign win   = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/count_mode_sched.sv
// Shares the ROM-driven mode counter between two requesters, granting
// round-robin and gating step_en for exactly the granted number of steps.
module count_mode_sched
  import count_sched_pkg::*;
#(
  parameter int unsigned STEP_W = StepWDefault,
  parameter int unsigned MODE_W = ModeWDefault
) (
  input  logic               clk,
  input  logic               res,
  count_mode_sched_if.slave  bus
);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              aborted_q, aborted_d;

  logic              win, valid;
  logic              gnt0, gnt1, step_en, done;
  logic [STEP_W-1:0] win_steps;

  rr_arb2 u_arb (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (last_q),
    .win   (win),
    .valid (valid)
  );

  assign win_steps = win ? bus.steps1 : bus.steps0;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aborted_d = aborted_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    step_en   = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (valid) begin
          gnt0    = ~win;
          gnt1    = win;
          mode_d  = win ? bus.mode1 : bus.mode0;
          owner_d = win;
          last_d  = win;
          rem_d   = win_steps;
          state_d = (win_steps != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        step_en = 1'b1;
        rem_d   = rem_q - STEP_W'(1);
        // Natural completion wins over a coincident abort.
        if (rem_q == STEP_W'(1)) begin
          state_d = StDone;
        end else if (bus.abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end
      end
      StDone: begin
        done      = 1'b1;
        aborted_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      rem_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rem_q     <= rem_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.mode    = mode_q;
  assign bus.step_en = step_en;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done;
  assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_count_mode_sched.sv
// Directed bench for count_mode_sched with a run-result scoreboard.
module tb_count_mode_sched;

  logic clk;
  logic res;

  count_mode_sched_if #(.STEP_W(4), .MODE_W(2)) bus ();

  count_mode_sched #(.STEP_W(4), .MODE_W(2)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       owner;
    logic [1:0] mode;
    int         steps;
    logic       ab;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   run_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic o, input logic [1:0] m, input int s, input logic a);
    exp_t x;
    x.owner = o;
    x.mode  = m;
    x.steps = s;
    x.ab    = a;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("done_within_budget", seen, 1'b1);
  endtask

  task automatic wait_gnt(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) seen = 1'b1;
    end
    check("gnt_within_budget", seen, 1'b1);
  endtask

  // Scoreboard: count step_en cycles per granted run, compare at done.
  always @(negedge clk) begin
    if (res) begin
      run_cnt = 0;
    end else begin
      if (bus.gnt0 || bus.gnt1) begin
        check("gnt_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
        run_cnt = 0;
      end
      if (bus.step_en) run_cnt++;
      if (bus.done) begin
        check("sb_expected_done", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_owner", bus.owner, e.owner);
          check("sb_mode", bus.mode, e.mode);
          check("sb_steps", run_cnt, e.steps);
          check("sb_aborted", bus.aborted, e.ab);
        end
      end
    end
  end

  initial begin
    res = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.abort = 0;
    bus.mode0 = 0; bus.mode1 = 0; bus.steps0 = 0; bus.steps1 = 0;
    step(); step();
    samp();
    check("rst_busy", bus.busy, 0);
    check("rst_mode", bus.mode, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_step_en", bus.step_en, 0);
    check("rst_done", bus.done, 0);
    check("rst_aborted", bus.aborted, 0);
    check("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    step();
    res = 1'b0;

    // Single request, mode 2, 3 steps.
    step();
    bus.req0 = 1; bus.mode0 = 2; bus.steps0 = 3;
    samp();
    check("single_gnt0", bus.gnt0, 1);
    check("single_gnt1", bus.gnt1, 0);
    check("single_busy_c0", bus.busy, 0);
    push(0, 2, 3, 0);
    step();
    bus.req0 = 0;
    samp();
    check("single_mode_c1", bus.mode, 2);
    check("single_step_c1", bus.step_en, 1);
    check("single_busy_c1", bus.busy, 1);
    step(); samp(); check("single_step_c2", bus.step_en, 1);
    step(); samp(); check("single_step_c3", bus.step_en, 1);
    step(); samp();
    check("single_done_c4", bus.done, 1);
    check("single_abt_c4", bus.aborted, 0);
    check("single_step_c4", bus.step_en, 0);
    step(); samp(); check("single_idle_c5", bus.busy, 0);

    // Contention: fresh reset so the first winner is 0.
    step();
    res = 1'b1;
    step();
    res = 1'b0;
    bus.req0 = 1; bus.req1 = 1; bus.mode0 = 1; bus.mode1 = 2;
    bus.steps0 = 1; bus.steps1 = 1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(10);
      check("rr_gnt0", bus.gnt0, (k % 2 == 0) ? 1 : 0);
      check("rr_gnt1", bus.gnt1, (k % 2 == 0) ? 0 : 1);
      push((k % 2 == 1), (k % 2 == 1) ? 2'd2 : 2'd1, 1, 0);
    end
    step();
    bus.req0 = 0; bus.req1 = 0;
    wait_done(8);

    // Zero-length run.
    step();
    bus.req1 = 1; bus.mode1 = 3; bus.steps1 = 0;
    samp();
    check("zero_gnt1", bus.gnt1, 1);
    check("zero_step_c0", bus.step_en, 0);
    push(1, 3, 0, 0);
    step();
    bus.req1 = 0;
    samp();
    check("zero_done_c1", bus.done, 1);
    check("zero_step_c1", bus.step_en, 0);
    step(); samp();
    check("zero_idle_c2", bus.busy, 0);
    check("zero_mode_c2", bus.mode, 3);
    repeat (3) step();
    samp();
    check("zero_mode_hold", bus.mode, 3);

    // Abort in the third RUN cycle of a 10-step run.
    step();
    bus.req0 = 1; bus.mode0 = 1; bus.steps0 = 10;
    samp();
    check("abt_gnt0", bus.gnt0, 1);
    push(0, 1, 3, 1);
    step();
    bus.req0 = 0;
    samp(); check("abt_step_c1", bus.step_en, 1);
    step(); samp(); check("abt_step_c2", bus.step_en, 1);
    step();
    bus.abort = 1;
    samp(); check("abt_step_c3", bus.step_en, 1);
    step();
    bus.abort = 0;
    samp();
    check("abt_done_c4", bus.done, 1);
    check("abt_aborted_c4", bus.aborted, 1);
    step(); samp();
    check("abt_idle_c5", bus.busy, 0);
    check("abt_cleared_c5", bus.aborted, 0);

    // Abort coinciding with the final step completes normally.
    step();
    bus.req0 = 1; bus.mode0 = 0; bus.steps0 = 2;
    samp();
    check("abtlast_gnt0", bus.gnt0, 1);
    push(0, 0, 2, 0);
    step();
    bus.req0 = 0;
    step();
    bus.abort = 1;
    samp(); check("abtlast_step_c2", bus.step_en, 1);
    step();
    bus.abort = 0;
    samp();
    check("abtlast_done", bus.done, 1);
    check("abtlast_aborted", bus.aborted, 0);

    // Request arriving while busy waits until IDLE.
    step();
    bus.req0 = 1; bus.mode0 = 0; bus.steps0 = 3;
    samp();
    check("wait_gnt0", bus.gnt0, 1);
    push(0, 0, 3, 0);
    step();
    bus.req0 = 0; bus.req1 = 1; bus.mode1 = 2; bus.steps1 = 1;
    for (int c = 1; c <= 4; c++) begin
      samp();
      check("wait_no_gnt1", bus.gnt1, 0);
      step();
    end
    samp();
    check("wait_gnt1_idle", bus.gnt1, 1);
    check("wait_busy_idle", bus.busy, 0);
    push(1, 2, 1, 0);
    step();
    bus.req1 = 0;
    wait_done(6);

    // Reset in the middle of a run.
    step();
    bus.req0 = 1; bus.mode0 = 3; bus.steps0 = 5;
    samp();
    check("rstrun_gnt0", bus.gnt0, 1);
    step();
    bus.req0 = 0;
    step();
    res = 1'b1;
    #1;
    check("rstrun_step_en", bus.step_en, 0);
    check("rstrun_busy", bus.busy, 0);
    check("rstrun_mode", bus.mode, 0);
    check("rstrun_done", bus.done, 0);
    step();
    res = 1'b0;
    step();
    bus.req1 = 1; bus.mode1 = 1; bus.steps1 = 2;
    samp();
    check("rstrun_fresh_gnt1", bus.gnt1, 1);
    push(1, 1, 2, 0);
    step();
    bus.req1 = 0;
    wait_done(6);
    step(); samp();
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_mode_sched.md
# count_mode_sched

Scheduler that shares the ROM-driven mode counter between two requesters. Each requester asks for a counting run: a 2-bit mode selecting the counter's ROM page, plus a step count. The block arbitrates round-robin, drives the counter's mode select, and gates its advance with a step enable for exactly the granted number of cycles. It sits between the requesting control logic and the counter's mode/enable inputs.

## Interface
- STEP_W, 4: width of the step-count request; max run is 2^STEP_W-1 steps.
- MODE_W, 2: width of the mode select driven to the counter's upper ROM address bits.
- clk  in  1  system clock, rising edge.
- res  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  run request; held high until the matching gnt pulse.
- mode0, mode1  in  MODE_W  requested mode; must be valid while req is high.
- steps0, steps1  in  STEP_W  requested step count; 0 is legal.
- abort  in  1  terminates the current run early; effective only in RUN.
- gnt0, gnt1  out  1  one-cycle grant pulse; at most one is high per cycle.
- mode  out  MODE_W  registered mode select to the counter.
- step_en  out  1  counter advance enable.
- owner  out  1  index of the requester whose run is current or last granted.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse marking the end of a run.
- aborted  out  1  qualifies done; high only if the run ended by abort.

## Operation
- Reset values: state=IDLE, mode=0, owner=0, last=1, remaining=0; all other outputs 0.
- States are IDLE, RUN and DONE.
- IDLE
  - With no request, stay in IDLE.
  - With any request, the arbiter picks a winner. A sole requester wins. If both request, the winner is !last.
  - The winner's gnt is combinational (Mealy) and asserted in this same cycle.
  - On the clock edge: mode <= winner's mode; owner <= winner; last <= winner; remaining <= winner's steps.
  - Next state is RUN if steps != 0, else DONE.
- RUN
  - step_en=1 every cycle; remaining decrements on each edge.
  - When remaining==1, next state is DONE.
  - If abort=1, the current cycle still has step_en=1 (that step counts). Next state is DONE with aborted latched to 1.
  - When abort and remaining==1 coincide, aborted=0: the run completed normally.
- DONE
  - done=1 for exactly one cycle; aborted is valid in this cycle.
  - Next state is IDLE; aborted clears on leaving DONE.
- The mode output holds its value after a run until the next grant, so the counter page is stable while idle.
- remaining is an unsigned STEP_W-bit register and never wraps: it is only decremented in RUN, where it is ≥1.
- No grants are issued outside IDLE. Requests arriving while busy wait, and keep their round-robin rank.
- A requester dropping req before gnt is legal; the request is simply not served.

## Timing
- With req seen in IDLE at cycle 0 and steps=N≥1:
  - gnt in cycle 0;
  - mode updates at the end of cycle 0;
  - step_en in cycles 1..N;
  - done in cycle N+1;
  - IDLE in cycle N+2, where the next grant may issue.
- With steps=0: gnt in cycle 0, done in cycle 1, IDLE in cycle 2.
- Throughput between back-to-back runs: 2 overhead cycles (the grant cycle is also the previous run's IDLE).
- Reset mid-run: step_en, done and busy drop asynchronously on res assertion. No done pulse is produced for the killed run.
- abort latency: asserted in RUN cycle k, step_en is last high in cycle k, done in cycle k+1.

## Structure
- Shared package count_sched_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default STEP_W and MODE_W constants.
- Sub-module rr_arb2 is a two-input round-robin arbiter. Inputs: req0, req1, last. Outputs: win, valid. It is purely combinational. The last register is kept in the parent.
- Top level holds the FSM, the mode/owner/remaining registers, and the output decode.

## Test plan
- Single request: after reset, req0=1, mode0=2, steps0=3 -> gnt0 in cycle 0, mode=2 from cycle 1, step_en in cycles 1-3, done in cycle 4 with aborted=0, busy low in cycle 5.
- Contention and fairness: req0 and req1 held high continuously with steps=1 each -> grants alternate 0,1,0,1. The first winner is 0 because last=1 at reset.
- Zero-length run: req1=1, steps1=0, mode1=3 -> gnt1, step_en never asserted, done one cycle later, mode=3 held afterwards.
- Abort: steps0=10, abort pulsed in the third RUN cycle -> exactly 3 step_en cycles, then done with aborted=1. Abort on the final step -> aborted=0.
- Request during run: req1 raised while req0's run is active -> no gnt1 until IDLE, then gnt1 in the first IDLE cycle.
- Reset mid-run: res asserted during RUN -> step_en and busy low immediately, mode=0, no done. After release, a fresh request is granted normally.
